// File: rtl/cpu_types_pkg.sv
// Shared types for the front end of the pipelined MIPS core.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // Widest tag needed: a 2-entry BTB leaves 29 tag bits above idx and byte offset.
  localparam int TAG_MAX_W = 29;

  localparam logic [1:0] BTB_CTR_WNT = 2'b01;
  localparam logic [1:0] BTB_CTR_WT  = 2'b10;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    word_t                target;
    logic [1:0]           ctr;
  } btb_entry_t;

  typedef struct packed {
    logic  valid;
    word_t instr;
    word_t pc;
    word_t npc;
    logic  pred;
    word_t ptarget;
  } ifid_t;

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit saturating counters.
// The lookup is combinational; training is registered, so a lookup of the same index sees the old contents.
module branch_target_buffer
  import cpu_types_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  word_t lu_pc,
  output logic  lu_hit,
  output word_t lu_target,
  input  logic  upd_en,
  input  word_t upd_pc,
  input  word_t upd_target,
  input  logic  upd_taken
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);

  btb_entry_t r_btb [BTB_ENTRIES];

  logic [IDX_W-1:0]     w_lu_idx, w_upd_idx;
  logic [TAG_MAX_W-1:0] w_lu_tag, w_upd_tag;
  btb_entry_t           w_lu_e, w_upd_e;
  logic                 w_upd_hit;
  logic                 w_unused;

  assign w_lu_idx  = lu_pc[IDX_W+1:2];
  assign w_upd_idx = upd_pc[IDX_W+1:2];
  assign w_lu_tag  = TAG_MAX_W'(lu_pc[31:IDX_W+2]);
  assign w_upd_tag = TAG_MAX_W'(upd_pc[31:IDX_W+2]);
  assign w_unused  = ^{lu_pc[1:0], upd_pc[1:0]};

  assign w_lu_e    = r_btb[w_lu_idx];
  assign w_upd_e   = r_btb[w_upd_idx];
  assign w_upd_hit = w_upd_e.valid && (w_upd_e.tag == w_upd_tag);

  assign lu_hit    = w_lu_e.valid && (w_lu_e.tag == w_lu_tag) && w_lu_e.ctr[1];
  assign lu_target = w_lu_e.target;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: BTB_CTR_WNT};
      end
    end else if (upd_en) begin
      if (w_upd_hit) begin
        if (upd_taken) begin
          r_btb[w_upd_idx].target <= upd_target;
          if (w_upd_e.ctr != 2'b11) r_btb[w_upd_idx].ctr <= w_upd_e.ctr + 2'd1;
        end else if (w_upd_e.ctr != 2'b00) begin
          r_btb[w_upd_idx].ctr <= w_upd_e.ctr - 2'd1;
        end
      end else if (upd_taken) begin
        // Only taken branches earn an entry; a not-taken miss would just evict useful state.
        r_btb[w_upd_idx] <= '{valid: 1'b1, tag: w_upd_tag, target: upd_target, ctr: BTB_CTR_WT};
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, BTB-predicted next-PC mux, IF/ID latch and sticky halt.
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT     = 32'h0,
  parameter int    BTB_ENTRIES = 16
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t iload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_pc,
  input  logic  halt,
  input  logic  upd_en,
  input  word_t upd_pc,
  input  word_t upd_target,
  input  logic  upd_taken,
  output logic  ifid_valid,
  output word_t ifid_instr,
  output word_t ifid_pc,
  output word_t ifid_npc,
  output logic  ifid_pred,
  output word_t ifid_ptarget
);

  word_t r_pc;
  logic  r_halted;
  ifid_t r_ifid;

  word_t w_pc4;
  logic  w_pred;
  word_t w_btb_target;
  word_t w_ptarget;
  logic  w_hold_pc;

  branch_target_buffer #(.BTB_ENTRIES(BTB_ENTRIES)) u_btb (
    .CLK        (CLK),
    .nRST       (nRST),
    .lu_pc      (r_pc),
    .lu_hit     (w_pred),
    .lu_target  (w_btb_target),
    .upd_en     (upd_en),
    .upd_pc     (upd_pc),
    .upd_target (upd_target),
    .upd_taken  (upd_taken)
  );

  assign w_pc4     = r_pc + 32'd4;
  assign w_ptarget = w_pred ? w_btb_target : w_pc4;
  assign w_hold_pc = r_halted || halt || stall || !ihit;

  assign iREN  = !r_halted;
  assign iaddr = r_pc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_pc <= {PC_INIT[31:2], 2'b00};
    end else if (redirect) begin
      r_pc <= {redirect_pc[31:2], 2'b00};
    end else if (!w_hold_pc) begin
      r_pc <= {w_ptarget[31:2], 2'b00};
    end
  end

  // A HALT that is being squashed by a redirect never reached a committed path.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_halted <= 1'b0;
    end else if (halt && !redirect) begin
      r_halted <= 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_ifid <= '0;
    end else if (redirect || r_halted || halt) begin
      r_ifid <= '0;
    end else if (stall) begin
      r_ifid <= r_ifid;
    end else if (ihit) begin
      r_ifid <= '{valid: 1'b1, instr: iload, pc: r_pc, npc: w_pc4,
                  pred: w_pred, ptarget: w_ptarget};
    end else begin
      r_ifid <= '0;
    end
  end

  assign ifid_valid   = r_ifid.valid;
  assign ifid_instr   = r_ifid.instr;
  assign ifid_pc      = r_ifid.pc;
  assign ifid_npc     = r_ifid.npc;
  assign ifid_pred    = r_ifid.pred;
  assign ifid_ptarget = r_ifid.ptarget;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed-vector bench for fetch_stage: a table of per-cycle stimulus with expected post-edge state.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0;
  logic [31:0] iload = '0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        upd_en = 1'b0;
  logic [31:0] upd_pc = '0;
  logic [31:0] upd_target = '0;
  logic        upd_taken = 1'b0;
  logic        ifid_valid;
  logic [31:0] ifid_instr, ifid_pc, ifid_npc, ifid_ptarget;
  logic        ifid_pred;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  fetch_stage #(.PC_INIT(32'h0), .BTB_ENTRIES(16)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .iload(iload), .iREN(iREN), .iaddr(iaddr),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_target(upd_target), .upd_taken(upd_taken),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_npc(ifid_npc), .ifid_pred(ifid_pred), .ifid_ptarget(ifid_ptarget)
  );

  typedef struct {
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
    logic        upd;
    logic [31:0] upc;
    logic [31:0] utgt;
    logic        utk;
    logic [31:0] e_iaddr;
    logic        e_iren;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_pred;
    logic [31:0] e_ptarget;
  } vec_t;

  function automatic vec_t mk(
    input logic ih, input logic [31:0] il, input logic st, input logic rd, input logic [31:0] rp,
    input logic hl, input logic ue, input logic [31:0] up, input logic [31:0] ut, input logic uk,
    input logic [31:0] ea, input logic er, input logic ev, input logic [31:0] ei,
    input logic [31:0] ep, input logic epr, input logic [31:0] et);
    vec_t v;
    v.ihit = ih; v.iload = il; v.stall = st; v.redir = rd; v.rpc = rp; v.halt = hl;
    v.upd = ue; v.upc = up; v.utgt = ut; v.utk = uk;
    v.e_iaddr = ea; v.e_iren = er; v.e_valid = ev; v.e_instr = ei;
    v.e_pc = ep; v.e_pred = epr; v.e_ptarget = et;
    return v;
  endfunction

  // Idle cycle (optional miss / BTB training) ending in a bubble at PC a with iREN r.
  function automatic vec_t bub(input logic [31:0] a, input logic r);
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, a, r, 0, 0, 0, 0, 0);
  endfunction

  task automatic chk(input string name, input int step, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int step);
    ihit = v.ihit; iload = v.iload; stall = v.stall; redirect = v.redir; redirect_pc = v.rpc;
    halt = v.halt; upd_en = v.upd; upd_pc = v.upc; upd_target = v.utgt; upd_taken = v.utk;
    @(posedge CLK);
    #1;
    chk("iaddr",   step, iaddr,        v.e_iaddr);
    chk("iREN",    step, 32'(iREN),    32'(v.e_iren));
    chk("valid",   step, 32'(ifid_valid), 32'(v.e_valid));
    chk("instr",   step, ifid_instr,   v.e_instr);
    chk("pc",      step, ifid_pc,      v.e_pc);
    chk("npc",     step, ifid_npc,     v.e_valid ? v.e_pc + 32'd4 : 32'h0);
    chk("pred",    step, 32'(ifid_pred), 32'(v.e_pred));
    chk("ptarget", step, ifid_ptarget, v.e_ptarget);
  endtask

  task automatic upd_bub(input logic [31:0] a, input logic [31:0] up, input logic [31:0] ut,
                         input logic uk, input int step);
    vec_t v;
    v = bub(a, 1);
    v.upd = 1; v.upc = up; v.utgt = ut; v.utk = uk;
    apply(v, step);
  endtask

  task automatic redir_bub(input logic [31:0] rp, input int step);
    vec_t v;
    v = bub(rp, 1);
    v.redir = 1; v.rpc = rp; v.ihit = 1; v.iload = 32'hDEAD_BEEF;
    apply(v, step);
  endtask

  task automatic reset_checks(input int step);
    chk("rst_iaddr", step, iaddr, 32'h0);
    chk("rst_iREN",  step, 32'(iREN), 32'h1);
    chk("rst_valid", step, 32'(ifid_valid), 32'h0);
    chk("rst_instr", step, ifid_instr, 32'h0);
    chk("rst_pc",    step, ifid_pc, 32'h0);
    chk("rst_pred",  step, 32'(ifid_pred), 32'h0);
  endtask

  vec_t tbl[$];

  initial begin
    // Sequential fetch, two-cycle miss at PC 8, then BTB allocation on 0x10.
    tbl.push_back(mk(1, 32'h2000_0000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h04, 1, 1, 32'h2000_0000, 32'h00, 0, 32'h04));
    tbl.push_back(mk(1, 32'h2000_0004, 0, 0, 0, 0, 0, 0, 0, 0, 32'h08, 1, 1, 32'h2000_0004, 32'h04, 0, 32'h08));
    tbl.push_back(bub(32'h08, 1));
    tbl.push_back(bub(32'h08, 1));
    tbl.push_back(mk(1, 32'h2000_0008, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0C, 1, 1, 32'h2000_0008, 32'h08, 0, 32'h0C));
    tbl.push_back(mk(1, 32'h2000_000C, 0, 0, 0, 0, 0, 0, 0, 0, 32'h10, 1, 1, 32'h2000_000C, 32'h0C, 0, 32'h10));
    // Same-cycle lookup and training of 0x10: lookup sees the empty entry.
    tbl.push_back(mk(1, 32'h2000_0010, 0, 0, 0, 0, 1, 32'h10, 32'h40, 1, 32'h14, 1, 1, 32'h2000_0010, 32'h10, 0, 32'h14));
    tbl.push_back(mk(1, 32'hDEAD_BEEF, 0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h10, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h2000_0010, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 1, 32'h2000_0010, 32'h10, 1, 32'h40));
    // Stall holds PC and IF/ID; stall with redirect lets the redirect through.
    tbl.push_back(mk(1, 32'h2000_0040, 1, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 1, 32'h2000_0010, 32'h10, 1, 32'h40));
    tbl.push_back(mk(1, 32'h2000_0040, 1, 1, 32'h80, 0, 0, 0, 0, 0, 32'h80, 1, 0, 0, 0, 0, 0));

    nRST = 1'b0;
    #12;
    reset_checks(0);
    @(negedge CLK);
    nRST = 1'b1;
    #1;

    foreach (tbl[i]) apply(tbl[i], i + 1);

    // Counter training: 10 -> 11 -> 11 -> 10 (still taken) -> 01 (not taken).
    upd_bub(32'h80, 32'h10, 32'h40, 1, 20);
    upd_bub(32'h80, 32'h10, 32'h40, 1, 21);
    upd_bub(32'h80, 32'h10, 32'h40, 0, 22);
    redir_bub(32'h10, 23);
    apply(mk(1, 32'h2000_0010, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 1, 32'h2000_0010, 32'h10, 1, 32'h40), 24);
    upd_bub(32'h40, 32'h10, 32'h40, 0, 25);
    redir_bub(32'h10, 26);
    apply(mk(1, 32'h2000_0010, 0, 0, 0, 0, 0, 0, 0, 0, 32'h14, 1, 1, 32'h2000_0010, 32'h10, 0, 32'h14), 27);

    // Squashed HALT is ignored; a real HALT freezes fetch permanently.
    apply(mk(1, 32'hDEAD_BEEF, 0, 1, 32'h100, 1, 0, 0, 0, 0, 32'h100, 1, 0, 0, 0, 0, 0), 30);
    apply(mk(1, 32'h2000_0100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 1, 1, 32'h2000_0100, 32'h100, 0, 32'h104), 31);
    apply(mk(1, 32'h2000_0104, 0, 0, 0, 1, 0, 0, 0, 0, 32'h104, 0, 0, 0, 0, 0, 0), 32);
    apply(mk(1, 32'h2000_0104, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0, 0, 0, 0, 0), 33);
    apply(mk(1, 32'h2000_0104, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 0, 0, 0, 0, 0, 0), 34);

    // Asynchronous reset mid-cycle clears halt and the BTB.
    nRST = 1'b0;
    #2;
    reset_checks(40);
    @(negedge CLK);
    nRST = 1'b1;
    #1;

    // Redirect during a miss with training, then a tag-aliasing fetch and a not-taken miss.
    begin
      vec_t v;
      v = bub(32'h50, 1);
      v.redir = 1; v.rpc = 32'h50; v.upd = 1; v.upc = 32'h10; v.utgt = 32'h40; v.utk = 1;
      apply(v, 41);
    end
    upd_bub(32'h50, 32'h20, 32'h60, 0, 42);
    apply(mk(1, 32'h2000_0050, 0, 0, 0, 0, 0, 0, 0, 0, 32'h54, 1, 1, 32'h2000_0050, 32'h50, 0, 32'h54), 43);
    redir_bub(32'h20, 44);
    apply(mk(1, 32'h2000_0020, 0, 0, 0, 0, 0, 0, 0, 0, 32'h24, 1, 1, 32'h2000_0020, 32'h20, 0, 32'h24), 45);
    redir_bub(32'h10, 46);
    apply(mk(1, 32'h2000_0010, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40, 1, 1, 32'h2000_0010, 32'h10, 1, 32'h40), 47);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
